alu_control_unit: RTL

- Hardwired Moore control unit that sequences the single-bus datapath through fetch and execute of register-to-register ALU instructions.
- Drives every bus-out/register-in strobe, the memory Read strobe and the ALU opcode.
- Register operands are selected through Gra/Grb/Grc plus Rin/Rout; the select-and-encode logic in the datapath turns these into R0in..R15in / R0out..R15out.
- Replaces hand-sequenced control in benches.

---
 rtl/alu_control_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_control_unit.sv
// Hardwired Moore controller sequencing fetch/execute of register-to-register ALU ops.
// Optional SINGLE_STEP_EN adds a step input and a STEP_WAIT state between instructions.
module alu_control_unit #(
    parameter int IR_W       = 32,
    parameter int ALU_OP_W   = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [IR_W-1:0]     IR,
    input  logic                mem_ready,
    input  logic                stop,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Yin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                fault
);

    // RST idle | T0 PC->MAR | T1 memory read | T2 MDR->IR | T3 decode | T4 ALU | T5 write-back | HALT | STEP_WAIT
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
`ifdef SINGLE_STEP_EN
        , S_STEP_WAIT
`endif
    } state_t;

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    opcode;
    logic          is_binary;
    logic          is_unary;
    logic [3:0]    alu_code;
    logic          unused_ir;

    assign opcode    = IR[IR_W-1 -: 5];
    assign unused_ir = ^IR[IR_W-6:0];
    assign is_binary = (opcode >= 5'd3) && (opcode <= 5'd8);
    assign is_unary  = (opcode == 5'd16) || (opcode == 5'd17);

    always_comb begin
        alu_code = 4'd0;
        case (opcode)
            5'd3:    alu_code = 4'd1;
            5'd4:    alu_code = 4'd2;
            5'd5:    alu_code = 4'd3;
            5'd6:    alu_code = 4'd4;
            5'd7:    alu_code = 4'd5;
            5'd8:    alu_code = 4'd6;
            5'd16:   alu_code = 4'd7;
            5'd17:   alu_code = 4'd8;
            default: alu_code = 4'd0;
        endcase
    end

`ifdef SINGLE_STEP_EN
    localparam state_t S_END = S_STEP_WAIT;
    logic step_prev;

    // Advance on a rising step only, so a held step runs a single instruction.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) step_prev <= 1'b0;
        else        step_prev <= step;
    end
`else
    localparam state_t S_END = S_T0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_RST;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_RST: state <= S_T0;
                S_T0:  state <= S_T1;
                S_T1: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        state    <= S_T2;
                    end else if (wait_cnt == CW'(WAIT_LIMIT)) begin
                        wait_cnt <= '0;
                        fault    <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    if (is_binary || is_unary) state <= S_T4;
                    else if (opcode == 5'd26)  state <= stop ? S_HALT : S_END;
                    else if (opcode == 5'd27)  state <= S_HALT;
                    else begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end
                end
                S_T4: state <= S_T5;
                S_T5: state <= stop ? S_HALT : S_END;
                S_HALT: state <= S_HALT;
`ifdef SINGLE_STEP_EN
                S_STEP_WAIT: begin
                    if (stop)                   state <= S_HALT;
                    else if (step && !step_prev) state <= S_T0;
                end
`endif
                default: state <= S_RST;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; Yin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        alu_op = '0;
        run    = 1'b0;
        case (state)
            S_T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                run = 1'b1; Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin = (wait_cnt == '0);
            end
            S_T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (is_binary) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
            end
            S_T4: begin
                run    = 1'b1;
                Zin    = 1'b1;
                alu_op = ALU_OP_W'(alu_code);
                Rout   = is_binary || is_unary;
                Grc    = is_binary;
                Grb    = is_unary;
            end
            S_T5: begin
                run = 1'b1; Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
